// File: rtl/cpm_perst_sequencer.sv
// Reset/PERST sequencer for the CPM PCIe BMD endpoint: releases POR, then PERST,
// supervises link-up and re-pulses PERST a bounded number of times before failing.
module cpm_perst_sequencer #(
  parameter int RESET_HOLD_CYCLES  = 500,
  parameter int PERST_DELAY_CYCLES = 16,
  parameter int LINKUP_TIMEOUT     = 1000000,
  parameter int MAX_RETRIES        = 3,
  parameter int CNT_WIDTH          = 24
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       soft_reset_req,
  input  logic       user_lnk_up,
  output logic       por_n,
  output logic       cpm_por_n,
  output logic       perst0_n,
  output logic       perst1_n,
  output logic       link_ok,
  output logic       timeout_err,
  output logic [1:0] retry_cnt,
  output logic [7:0] link_drop_cnt,
  output logic [2:0] state
);

  // HOLD | POR_WAIT | WAIT_LINK | LINK_UP | PERST_HOLD | FAIL (absorbing until soft reset)
  typedef enum logic [2:0] {
    S_HOLD       = 3'd0,
    S_POR_WAIT   = 3'd1,
    S_WAIT_LINK  = 3'd2,
    S_LINK_UP    = 3'd3,
    S_PERST_HOLD = 3'd4,
    S_FAIL       = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(PERST_DELAY_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(LINKUP_TIMEOUT - 1);
  localparam logic [1:0]           MAX_R      = 2'(MAX_RETRIES);

  state_t               st;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 lnk_meta;
  logic                 lnk_sync;

  assign state = st;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lnk_meta <= 1'b0;
      lnk_sync <= 1'b0;
    end else begin
      lnk_meta <= user_lnk_up;
      lnk_sync <= lnk_meta;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st            <= S_HOLD;
      cnt           <= '0;
      por_n         <= 1'b0;
      cpm_por_n     <= 1'b0;
      perst0_n      <= 1'b0;
      perst1_n      <= 1'b0;
      link_ok       <= 1'b0;
      timeout_err   <= 1'b0;
      retry_cnt     <= 2'd0;
      link_drop_cnt <= 8'd0;
    end else if (soft_reset_req) begin
      // link_drop_cnt deliberately survives a soft restart
      st          <= S_HOLD;
      cnt         <= '0;
      por_n       <= 1'b0;
      cpm_por_n   <= 1'b0;
      perst0_n    <= 1'b0;
      perst1_n    <= 1'b0;
      link_ok     <= 1'b0;
      timeout_err <= 1'b0;
      retry_cnt   <= 2'd0;
    end else begin
      cnt <= cnt + CNT_WIDTH'(1);
      case (st)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            st        <= S_POR_WAIT;
            cnt       <= '0;
            por_n     <= 1'b1;
            cpm_por_n <= 1'b1;
          end
        end
        S_POR_WAIT: begin
          if (cnt == DELAY_LAST) begin
            st       <= S_WAIT_LINK;
            cnt      <= '0;
            perst0_n <= 1'b1;
            perst1_n <= 1'b1;
          end
        end
        S_WAIT_LINK: begin
          if (lnk_sync) begin
            st      <= S_LINK_UP;
            cnt     <= '0;
            link_ok <= 1'b1;
          end else if (cnt == TO_LAST) begin
            cnt      <= '0;
            perst0_n <= 1'b0;
            perst1_n <= 1'b0;
            if (retry_cnt < MAX_R) begin
              st        <= S_PERST_HOLD;
              retry_cnt <= retry_cnt + 2'd1;
            end else begin
              st          <= S_FAIL;
              timeout_err <= 1'b1;
            end
          end
        end
        S_LINK_UP: begin
          if (!lnk_sync) begin
            st      <= S_WAIT_LINK;
            cnt     <= '0;
            link_ok <= 1'b0;
            if (link_drop_cnt != 8'hFF) link_drop_cnt <= link_drop_cnt + 8'd1;
          end
        end
        S_PERST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            st       <= S_WAIT_LINK;
            cnt      <= '0;
            perst0_n <= 1'b1;
            perst1_n <= 1'b1;
          end
        end
        S_FAIL: begin
          cnt <= cnt;
        end
        default: begin
          st  <= S_HOLD;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpm_perst_sequencer.sv
// Scoreboard bench for cpm_perst_sequencer: stimulus queues expected output
// snapshots keyed by edge number, a monitor pops and compares them.
module tb_cpm_perst_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       soft_reset_req = 1'b0;
  logic       user_lnk_up = 1'b0;
  logic       por_n, cpm_por_n, perst0_n, perst1_n, link_ok, timeout_err;
  logic [1:0] retry_cnt;
  logic [7:0] link_drop_cnt;
  logic [2:0] state;

  cpm_perst_sequencer #(
    .RESET_HOLD_CYCLES (8),
    .PERST_DELAY_CYCLES(4),
    .LINKUP_TIMEOUT    (20),
    .MAX_RETRIES       (2),
    .CNT_WIDTH         (24)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .soft_reset_req(soft_reset_req),
    .user_lnk_up   (user_lnk_up),
    .por_n         (por_n),
    .cpm_por_n     (cpm_por_n),
    .perst0_n      (perst0_n),
    .perst1_n      (perst1_n),
    .link_ok       (link_ok),
    .timeout_err   (timeout_err),
    .retry_cnt     (retry_cnt),
    .link_drop_cnt (link_drop_cnt),
    .state         (state)
  );

  always #5 sys_clk = ~sys_clk;

  // edge number since the last reset release
  int cyc;
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  typedef struct {
    int          cyc;
    bit          imm;
    string       name;
    logic [18:0] v;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic imm_tick = 1'b0;

  wire [18:0] act = {por_n, cpm_por_n, perst0_n, perst1_n, link_ok, timeout_err,
                     retry_cnt, link_drop_cnt, state};

  function automatic logic [18:0] exp_vec(bit por, bit pst, bit lk, bit te,
                                          int rc, int ldc, int st);
    return {por, por, pst, pst, lk, te, 2'(rc), 8'(ldc), 3'(st)};
  endfunction

  function automatic void push(int c, string name, logic [18:0] v);
    exp_t e;
    e.cyc = c; e.imm = 1'b0; e.name = name; e.v = v;
    q.push_back(e);
  endfunction

  function automatic void compare(exp_t e);
    checks++;
    if (act !== e.v) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h expected=%h (por,cpor,p0,p1,lk,te,rc[2],ldc[8],st[3])",
               e.name, cyc, act, e.v);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk or imm_tick);
      if (q.size() > 0 && q[0].imm) begin
        e = q.pop_front();
        compare(e);
      end
      while (q.size() > 0 && !q[0].imm && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s missed: now edge=%0d required edge=%0d", e.name, cyc, e.cyc);
        end else begin
          compare(e);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int b;
    exp_t e;
    push(0, "reset_vals", exp_vec(0,0,0,0,0,0,0));
    #22 sys_rst_n = 1'b1;

    // nominal bring-up and link-up
    push(7,  "hold_end",   exp_vec(0,0,0,0,0,0,0));
    push(8,  "por_rise",   exp_vec(1,0,0,0,0,0,1));
    push(11, "por_wait",   exp_vec(1,0,0,0,0,0,1));
    push(12, "perst_rise", exp_vec(1,1,0,0,0,0,2));
    push(16, "link_sync",  exp_vec(1,1,0,0,0,0,2));
    push(17, "link_up",    exp_vec(1,1,1,0,0,0,3));
    tick(14);
    user_lnk_up = 1'b1;
    tick(6);

    // single-edge link drop
    push(22, "pre_drop",   exp_vec(1,1,1,0,0,0,3));
    push(23, "drop1",      exp_vec(1,1,0,0,0,1,2));
    push(24, "relink",     exp_vec(1,1,1,0,0,1,3));
    user_lnk_up = 1'b0;
    tick(1);
    user_lnk_up = 1'b1;
    tick(3);

    // 299 further drops: counter saturates at 255
    for (int i = 0; i < 299; i++) begin
      user_lnk_up = 1'b0;
      tick(1);
      user_lnk_up = 1'b1;
      tick(1);
    end
    push(cyc + 4, "drop_sat", exp_vec(1,1,1,0,0,255,3));
    tick(5);

    // soft reset on the same edge the synced link-up is seen in WAIT_LINK
    b = cyc;
    push(b + 3,  "drop_at_sat",  exp_vec(1,1,0,0,0,255,2));
    push(b + 4,  "soft_vs_link", exp_vec(0,0,0,0,0,255,0));
    push(b + 11, "hold_soft",    exp_vec(0,0,0,0,0,255,0));
    push(b + 12, "por_soft",     exp_vec(1,0,0,0,0,255,1));
    push(b + 16, "perst_soft",   exp_vec(1,1,0,0,0,255,2));
    push(b + 17, "link_soft",    exp_vec(1,1,1,0,0,255,3));
    user_lnk_up = 1'b0;
    tick(1);
    user_lnk_up = 1'b1;
    tick(2);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    tick(b + 18 - cyc);

    // retry then fail, restarted from LINK_UP via soft reset
    b = cyc + 1;
    push(b,      "soft_from_up", exp_vec(0,0,0,0,0,255,0));
    push(b + 31, "wait_pre_to",  exp_vec(1,1,0,0,0,255,2));
    push(b + 32, "retry1_fall",  exp_vec(1,0,0,0,1,255,4));
    push(b + 39, "retry1_hold",  exp_vec(1,0,0,0,1,255,4));
    push(b + 40, "retry1_rise",  exp_vec(1,1,0,0,1,255,2));
    push(b + 60, "retry2_fall",  exp_vec(1,0,0,0,2,255,4));
    push(b + 68, "retry2_rise",  exp_vec(1,1,0,0,2,255,2));
    push(b + 87, "wait_pre_fail",exp_vec(1,1,0,0,2,255,2));
    push(b + 88, "fail",         exp_vec(1,0,0,1,2,255,5));
    push(b + 95, "fail_hold",    exp_vec(1,0,0,1,2,255,5));
    user_lnk_up = 1'b0;
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    tick(96);

    // soft reset out of FAIL
    b = cyc + 1;
    push(b,      "soft_from_fail", exp_vec(0,0,0,0,0,255,0));
    push(b + 7,  "hold_after_fail",exp_vec(0,0,0,0,0,255,0));
    push(b + 8,  "por_after_fail", exp_vec(1,0,0,0,0,255,1));
    push(b + 32, "retry_again",    exp_vec(1,0,0,0,1,255,4));
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    tick(35);

    // async reset in the middle of PERST_HOLD, away from any clock edge
    #2 sys_rst_n = 1'b0;
    e.cyc = 0; e.imm = 1'b1; e.name = "async_rst"; e.v = exp_vec(0,0,0,0,0,0,0);
    q.push_back(e);
    #1 imm_tick = ~imm_tick;
    repeat (2) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;

    // link-up and timeout on the same edge: link-up wins
    push(31, "to_pending",         exp_vec(1,1,0,0,0,0,2));
    push(32, "link_beats_timeout", exp_vec(1,1,1,0,0,0,3));
    tick(29);
    user_lnk_up = 1'b1;
    tick(5);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge sys_clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never checked: required edge=%0d", e.name, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
